// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - instruction memory responder with host program loader
//
// Serves the CPU fetch port combinationally and loads the program through a
// byte-wide valid/ready write port. The CPU is held in reset for the whole
// load and for RESET_HOLD clk cycles after the last byte is accepted.
//
// Optional feature macro: IMEM_CHECKSUM_EN (modulo-256 sum of accepted bytes).
//
// Ports:
//   clk          system clock, rising edge
//   Reset        synchronous active-high reset
//   load_start   pulse: begin a new load at address 0 (also restarts a load)
//   wr_valid     host offers wr_data
//   wr_data      program byte
//   wr_last      wr_data is the final program byte
//   wr_ready     byte accepted this cycle when wr_valid is high (LOAD only)
//   ReadAddress  CPU fetch address
//   Instruction  fetched word, PAD_WORD beyond the loaded length
//   cpu_reset    reset to the CPU core
//   prog_len     number of loaded words (0..2**ADDR_W)
//   state        debug state: IDLE=0, LOAD=1, HOLD=2, RUN=3
//   checksum     byte sum of the current load (0 when the feature is off)

module imem_loader #(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] PAD_WORD   = 8'h00,
  parameter int                RESET_HOLD = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] ReadAddress,
  output logic [DATA_W-1:0] Instruction,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   prog_len,
  output logic [1:0]        state,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic              mem_we;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prog_len_d = prog_len_q;
    hold_cnt_d = hold_cnt_q;
    mem_we     = 1'b0;
    wr_ready   = 1'b0;
    cpu_reset  = 1'b1;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        // load_start wins over a byte offered in the same cycle
        if (load_start) begin
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end else if (wr_valid) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
          prog_len_d = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
          // the top address ends the load: the pointer wraps but is never used
          if (wr_last || (wr_ptr_q == {ADDR_W{1'b1}})) begin
            state_d    = HOLD;
            hold_cnt_d = 8'(RESET_HOLD);
          end
        end
      end
      HOLD: begin
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
          if (hold_cnt_q == 8'd1) state_d = RUN;
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        if (load_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prog_len_q <= prog_len_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Contents survive Reset; prog_len=0 masks them until reloaded.
  always_ff @(posedge clk) begin
    if (mem_we && !Reset) mem[wr_ptr_q] <= wr_data;
  end

  assign Instruction = ({1'b0, ReadAddress} < prog_len_q) ? mem[ReadAddress] : PAD_WORD;
  assign prog_len    = prog_len_q;
  assign state       = state_q;

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (load_start) checksum_d = '0;
    else if (mem_we) checksum_d = checksum_q + wr_data;
  end

  always_ff @(posedge clk) begin
    if (Reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard testbench for imem_loader

module tb_imem_loader;

  logic       clk = 1'b0;
  logic       Reset;
  logic       load_start;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_last;
  logic       wr_ready;
  logic [7:0] ReadAddress;
  logic [7:0] Instruction;
  logic       cpu_reset;
  logic [8:0] prog_len;
  logic [1:0] state;
  logic [7:0] checksum;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W(8), .DATA_W(8), .PAD_WORD(8'h00), .RESET_HOLD(16)
  ) dut (
    .clk(clk), .Reset(Reset), .load_start(load_start),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .ReadAddress(ReadAddress),
    .Instruction(Instruction), .cpu_reset(cpu_reset),
    .prog_len(prog_len), .state(state), .checksum(checksum)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_sum;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] chk_exp();
`ifdef IMEM_CHECKSUM_EN
    return exp_sum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_sum = 8'h00;
  endtask

  // Offer one byte; the expected memory word is queued as it is driven.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] addr);
    int w;
    w = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    while (!wr_ready && w < 20) begin
      tick();
      w++;
    end
    if (!wr_ready) check_val("wr_ready_timeout", 32'(wr_ready), 32'd1);
    sb.push_back('{addr, d});
    exp_sum += d;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Idle cycle with junk data and wr_last that must be ignored.
  task automatic gap();
    wr_valid = 1'b0;
    wr_data  = 8'hEE;
    wr_last  = 1'b1;
    tick();
    wr_last  = 1'b0;
  endtask

  task automatic drain_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ReadAddress = e.addr;
      #1;
      check_val($sformatf("rd[%02h]", e.addr), 32'(Instruction), 32'(e.data));
    end
  endtask

  task automatic wait_run();
    int c;
    c = 0;
    while (cpu_reset && c < 300) begin
      tick();
      c++;
    end
    check_val("hold_cycles", c, 16);
    check_val("run_state", 32'(state), 32'd3);
  endtask

  task automatic check_pad(input logic [7:0] a, input string tag);
    ReadAddress = a;
    #1;
    check_val(tag, 32'(Instruction), 32'h00);
  endtask

  initial begin
    Reset = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    wr_last = 1'b0; ReadAddress = 8'h05; exp_sum = 8'h00;
    tick(); tick();
    Reset = 1'b0;
    #1;
    check_val("rst_instr", 32'(Instruction), 32'h00);
    check_val("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_prog_len", 32'(prog_len), 32'd0);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_val("rst_checksum", 32'(checksum), 32'h00);

    // Continuous three-byte load
    start_load();
    check_val("load_wr_ready", 32'(wr_ready), 32'd1);
    send_byte(8'h51, 1'b0, 8'd0);
    send_byte(8'h6A, 1'b0, 8'd1);
    send_byte(8'hC3, 1'b1, 8'd2);
    check_val("c3_state", 32'(state), 32'd2);
    check_val("c3_prog_len", 32'(prog_len), 32'd3);
    check_val("c3_wr_ready", 32'(wr_ready), 32'd0);
    check_val("c3_checksum", 32'(checksum), 32'(chk_exp()));
    wait_run();
    drain_sb();
    check_pad(8'd3, "c3_pad");

    // Same bytes with gaps in wr_valid
    start_load();
    send_byte(8'h51, 1'b0, 8'd0);
    gap();
    send_byte(8'h6A, 1'b0, 8'd1);
    gap();
    send_byte(8'hC3, 1'b1, 8'd2);
    check_val("gap_prog_len", 32'(prog_len), 32'd3);
    check_val("gap_checksum", 32'(checksum), 32'(chk_exp()));
    wait_run();
    drain_sb();
    check_pad(8'd3, "gap_pad");

    // Full 256-byte load, wr_last never asserted
    start_load();
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0, 8'(i));
    check_val("full_state", 32'(state), 32'd2);
    check_val("full_prog_len", 32'(prog_len), 32'd256);
    check_val("full_checksum", 32'(checksum), 32'(chk_exp()));
    wait_run();
    drain_sb();

    // Restart from RUN with a byte offered alongside load_start
    load_start = 1'b1; wr_valid = 1'b1; wr_data = 8'hAA; wr_last = 1'b1;
    tick();
    load_start = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
    exp_sum = 8'h00;
    check_val("rs_cpu_reset", 32'(cpu_reset), 32'd1);
    check_val("rs_state", 32'(state), 32'd1);
    check_val("rs_prog_len", 32'(prog_len), 32'd0);
    check_val("rs_checksum", 32'(checksum), 32'h00);
    send_byte(8'h3C, 1'b1, 8'd0);
    check_val("rs_prog_len1", 32'(prog_len), 32'd1);
    wait_run();
    drain_sb();
    check_pad(8'd1, "rs_pad");

    // Restart inside LOAD: the concurrent byte must not be taken
    start_load();
    send_byte(8'h11, 1'b0, 8'd0);
    send_byte(8'h22, 1'b0, 8'd1);
    load_start = 1'b1; wr_valid = 1'b1; wr_data = 8'hAA; wr_last = 1'b0;
    tick();
    load_start = 1'b0; wr_valid = 1'b0;
    sb.delete();
    exp_sum = 8'h00;
    check_val("lr_prog_len", 32'(prog_len), 32'd0);
    check_val("lr_state", 32'(state), 32'd1);
    send_byte(8'h44, 1'b1, 8'd0);
    check_val("lr_prog_len1", 32'(prog_len), 32'd1);
    check_val("lr_checksum", 32'(checksum), 32'(chk_exp()));
    wait_run();
    drain_sb();

    // Reset in the middle of a load
    start_load();
    send_byte(8'h80, 1'b0, 8'd0);
    send_byte(8'h90, 1'b0, 8'd1);
    sb.delete();
    check_val("mr_prog_len", 32'(prog_len), 32'd2);
    check_val("mr_checksum_pre", 32'(checksum), 32'(chk_exp()));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("mr_state", 32'(state), 32'd0);
    check_val("mr_prog_len0", 32'(prog_len), 32'd0);
    check_val("mr_cpu_reset", 32'(cpu_reset), 32'd1);
    check_val("mr_checksum", 32'(checksum), 32'h00);
    check_pad(8'd0, "mr_pad0");
    check_pad(8'd1, "mr_pad1");
    check_pad(8'hFF, "mr_padff");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
